// File: rtl/axi_wdt_multi.sv
// axi_wdt_multi: NUM_CH watchdogs behind an AXI write-only slave; `WDT_PRESCALE_EN adds a shared tick prescaler.
// Register writes land on the W-beat edge; one burst in flight, W stalls only on WVALID_S, B holds until BREADY_S.
module axi_wdt_multi #(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32,
    parameter int          ID_W      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ID_W-1:0]   AWID_S,
    input  logic [31:0]       AWADDR_S,
    input  logic [3:0]        AWLEN_S,
    input  logic [1:0]        AWBURST_S,
    input  logic              AWVALID_S,
    output logic              AWREADY_S,
    input  logic [31:0]       WDATA_S,
    input  logic [3:0]        WSTRB_S,
    input  logic              WLAST_S,
    input  logic              WVALID_S,
    output logic              WREADY_S,
    output logic [ID_W-1:0]   BID_S,
    output logic [1:0]        BRESP_S,
    output logic              BVALID_S,
    input  logic              BREADY_S,
    output logic [NUM_CH-1:0] WTO
);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t          state;
    logic [31:0]     addr;
    logic [ID_W-1:0] id;
    logic            fixed;
    logic            err;

    logic [31:0] off;
    logic [27:0] blk;
    logic [1:0]  reg_idx;
    logic        in_ch;
    logic        mapped;
    logic        wbeat;
    logic        tick;

    assign off     = addr - BASE_ADDR;
    assign blk     = off[31:4];
    assign reg_idx = off[3:2];
    assign in_ch   = (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) && (off < 32'(16 * NUM_CH));
    assign wbeat   = (state == DATA) && WVALID_S;

`ifdef WDT_PRESCALE_EN
    logic        is_presc;
    logic [15:0] presc;
    logic [15:0] pcnt;

    assign is_presc = (addr == BASE_ADDR + 32'(16 * NUM_CH));
    assign mapped   = in_ch || is_presc;
    assign tick     = (pcnt == presc);

    // A PRESC write re-phases the prescaler so the new period starts cleanly.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            presc <= '0;
            pcnt  <= '0;
        end else if (wbeat && is_presc) begin
            if (WSTRB_S[0]) presc[7:0]  <= WDATA_S[7:0];
            if (WSTRB_S[1]) presc[15:8] <= WDATA_S[15:8];
            pcnt <= '0;
        end else begin
            pcnt <= tick ? 16'd0 : pcnt + 16'd1;
        end
    end
`else
    assign mapped = in_ch;
    assign tick   = 1'b1;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
            addr  <= '0;
            id    <= '0;
            fixed <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (AWVALID_S) begin
                    addr  <= AWADDR_S;
                    id    <= AWID_S;
                    fixed <= (AWBURST_S == 2'b00);
                    err   <= 1'b0;
                    state <= DATA;
                end
                // WLAST_S, not AWLEN_S, ends the burst.
                DATA: if (WVALID_S) begin
                    if (!mapped) err <= 1'b1;
                    if (!fixed) addr <= addr + 32'd4;
                    if (WLAST_S) state <= RESP;
                end
                RESP: if (BREADY_S) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign AWREADY_S = (state == IDLE);
    assign WREADY_S  = (state == DATA);
    assign BVALID_S  = (state == RESP);
    assign BID_S     = id;
    assign BRESP_S   = {(state == RESP) && err, 1'b0};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             sel;
        logic             wr_ctrl;
        logic             wr_to;
        logic             kick;
        logic             clr;
        logic             en;
        logic             wto;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_inc;
        logic [CNT_W-1:0] tocnt;
        logic [31:0]      to_wr;

        assign sel     = wbeat && in_ch && (blk == 28'(c));
        assign wr_ctrl = sel && (reg_idx == 2'd0) && WSTRB_S[0];
        assign kick    = sel && (reg_idx == 2'd1) && WSTRB_S[0] && (WDATA_S != 32'd0);
        assign wr_to   = sel && (reg_idx == 2'd2);
        assign clr     = sel && (reg_idx == 2'd3) && WSTRB_S[0] && WDATA_S[0];
        assign cnt_inc = cnt + 1'b1;

        always_comb begin
            to_wr = 32'(tocnt);
            for (int b = 0; b < 4; b++) begin
                if (WSTRB_S[b]) to_wr[8*b +: 8] = WDATA_S[8*b +: 8];
            end
        end

        // Kick/CLR take priority over a terminal count reached on the same edge.
        always_ff @(posedge ACLK or negedge ARESETn) begin
            if (!ARESETn) begin
                en    <= 1'b0;
                wto   <= 1'b0;
                cnt   <= '0;
                tocnt <= '0;
            end else begin
                if (wr_ctrl) en <= WDATA_S[0];
                if (wr_to) tocnt <= to_wr[CNT_W-1:0];
                if (clr) wto <= 1'b0;
                if (kick || clr || !en) begin
                    cnt <= '0;
                end else if (tick && !wto && (tocnt != '0)) begin
                    cnt <= cnt_inc;
                    if (cnt_inc == tocnt) wto <= 1'b1;
                end
            end
        end

        assign WTO[c] = wto;
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, AWLEN_S, off[1:0]};

endmodule

// File: tb/tb_axi_wdt_multi.sv
// Scoreboard bench for axi_wdt_multi: directed bursts plus a randomized phase against a per-channel watchdog model.
module tb_axi_wdt_multi;

    localparam int          NUM_CH = 4;
    localparam int          CNT_W  = 32;
    localparam int          ID_W   = 8;
    localparam logic [31:0] BASE   = 32'h1001_0000;
    localparam longint      MOD    = longint'(1) << CNT_W;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic [ID_W-1:0]   AWID_S = '0;
    logic [31:0]       AWADDR_S = '0;
    logic [3:0]        AWLEN_S = '0;
    logic [1:0]        AWBURST_S = 2'b01;
    logic              AWVALID_S = 1'b0;
    logic              AWREADY_S;
    logic [31:0]       WDATA_S = '0;
    logic [3:0]        WSTRB_S = '0;
    logic              WLAST_S = 1'b0;
    logic              WVALID_S = 1'b0;
    logic              WREADY_S;
    logic [ID_W-1:0]   BID_S;
    logic [1:0]        BRESP_S;
    logic              BVALID_S;
    logic              BREADY_S = 1'b1;
    logic [NUM_CH-1:0] WTO;

    axi_wdt_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ID_W(ID_W), .BASE_ADDR(BASE)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWBURST_S(AWBURST_S),
        .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .WTO(WTO)
    );

    always #5 ACLK = ~ACLK;

    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } exp_t;

    exp_t exp_q[$];
    int   resp_seen = 0;

    logic [31:0] bd[16];
    logic [3:0]  bs[16];

    // Reference model state: registers per channel and the counter's age in ticks.
    bit                m_en[NUM_CH];
    logic [31:0]       m_to[NUM_CH];
    longint            m_age[NUM_CH];
    logic [NUM_CH-1:0] m_wto;
    logic [31:0]       m_addr;
    bit                m_fixed;
    longint            beat_edge = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_mapped(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + 32'(16 * NUM_CH));
    endfunction

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    // Response monitor: pops the scoreboard on every B handshake.
    initial begin : b_monitor
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (ARESETn && BVALID_S && BREADY_S) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_b", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bid", BID_S, e.id);
                    chk("bresp", BRESP_S, e.resp);
                end
                resp_seen++;
            end
        end
    end

    // Watchdog model: compares WTO each cycle, then applies what the coming edge does.
    initial begin : wdt_model
        logic [31:0] off;
        int  ch, r;
        bit  beat, hit, kick, clr, z;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    m_en[c] = 0; m_to[c] = '0; m_age[c] = 0;
                end
                m_wto = '0; m_addr = '0; m_fixed = 0;
            end else begin
                chk("wto", WTO, m_wto);
                beat = WVALID_S && WREADY_S;
                hit  = beat && is_mapped(m_addr);
                off  = m_addr - BASE;
                ch   = int'(off >> 4);
                r    = int'(off[3:2]);
                kick = hit && r == 1 && WSTRB_S[0] && WDATA_S != 0;
                clr  = hit && r == 3 && WSTRB_S[0] && WDATA_S[0];
                for (int c = 0; c < NUM_CH; c++) begin
                    z = !m_en[c] || (ch == c && (kick || clr));
                    if (z) m_age[c] = 0;
                    else if (!m_wto[c] && m_to[c] != 0) begin
                        m_age[c]++;
                        if ((m_age[c] % MOD) == longint'(m_to[c])) m_wto[c] = 1'b1;
                    end
                end
                if (hit) begin
                    case (r)
                        0: if (WSTRB_S[0]) m_en[ch] = WDATA_S[0];
                        2: for (int b = 0; b < 4; b++) if (WSTRB_S[b]) m_to[ch][8*b +: 8] = WDATA_S[8*b +: 8];
                        3: if (clr) m_wto[ch] = 1'b0;
                        default: ;
                    endcase
                end
                if (beat) begin
                    beat_edge = cyc + 1;
                    if (!m_fixed) m_addr = m_addr + 32'd4;
                end
                if (AWVALID_S && AWREADY_S) begin
                    m_addr  = AWADDR_S;
                    m_fixed = (AWBURST_S == 2'b00);
                end
            end
        end
    end

    task automatic burst(input logic [ID_W-1:0] id, input logic [31:0] a0, input logic [1:0] bt,
                         input int n, input int hold);
        logic [31:0] a;
        bit   err;
        exp_t e;
        int   k, target;
        a = a0; err = 0;
        for (int i = 0; i < n; i++) begin
            if (!is_mapped(a)) err = 1;
            if (bt != 2'b00) a = a + 32'd4;
        end
        e.id = id; e.resp = err ? 2'b10 : 2'b00;
        exp_q.push_back(e);
        target = resp_seen + 1;
        @(posedge ACLK); #1;
        AWVALID_S = 1; AWID_S = id; AWADDR_S = a0; AWLEN_S = 4'(n - 1); AWBURST_S = bt;
        BREADY_S = (hold == 0);
        k = 0;
        do begin @(negedge ACLK); k++; end while (!AWREADY_S && k < 50);
        if (!AWREADY_S) chk("awready_timeout", AWREADY_S, 1);
        @(posedge ACLK); #1;
        AWVALID_S = 0;
        for (int i = 0; i < n; i++) begin
            WVALID_S = 1; WDATA_S = bd[i]; WSTRB_S = bs[i]; WLAST_S = (i == n - 1);
            k = 0;
            do begin @(negedge ACLK); k++; end while (!WREADY_S && k < 50);
            if (!WREADY_S) chk("wready_timeout", WREADY_S, 1);
            @(posedge ACLK); #1;
        end
        WVALID_S = 0; WLAST_S = 0;
        if (hold > 0) begin
            k = 0;
            do begin @(negedge ACLK); k++; end while (!BVALID_S && k < 50);
            repeat (hold) begin
                @(negedge ACLK);
                chk("hold_bvalid", BVALID_S, 1);
                chk("hold_bid", BID_S, id);
                chk("hold_bresp", BRESP_S, e.resp);
            end
            @(posedge ACLK); #1;
            BREADY_S = 1;
        end
        k = 0;
        while (resp_seen < target && k < 50) begin @(negedge ACLK); k++; end
        if (resp_seen < target) chk("bresp_timeout", resp_seen, target);
    endtask

    task automatic wr1(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [31:0] d);
        bd[0] = d; bs[0] = 4'hF;
        burst(id, a, 2'b01, 1, 0);
    endtask

    task automatic wait_wto(input int bitn, output longint rise);
        int k = 0;
        while (!WTO[bitn] && k < 60) begin @(negedge ACLK); k++; end
        rise = cyc;
    endtask

    initial begin : stim
        longint rise, kick_edge;
        int     n, hold;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin bd[i] = '0; bs[i] = 4'hF; end

        #1;
        chk("rst_awready", AWREADY_S, 1);
        chk("rst_wready", WREADY_S, 0);
        chk("rst_bvalid", BVALID_S, 0);
        chk("rst_bid", BID_S, 0);
        chk("rst_bresp", BRESP_S, 0);
        chk("rst_wto", WTO, 0);
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1;
        repeat (2) @(posedge ACLK);

        // Channel 0: TOCNT=5 then EN; WTO[0] is due 5 edges after the CTRL beat.
        wr1(8'h3C, BASE + 32'h8, 32'd5);
        wr1(8'h3C, BASE + 32'h0, 32'd1);
        wait_wto(0, rise);
        chk("wto0_delay", rise - beat_edge, 5);
        chk("wto_others_low", WTO[3:1], 0);

        // Channel 1: kicked every ~6 cycles it must not fire, then fires 10 after the last kick.
        wr1(8'h11, BASE + 32'h18, 32'd10);
        wr1(8'h11, BASE + 32'h10, 32'd1);
        repeat (6) begin
            wr1(8'h12, BASE + 32'h14, 32'hA5);
            repeat (3) @(posedge ACLK);
        end
        kick_edge = beat_edge;
        chk("wto1_kicked", WTO[1], 0);
        wait_wto(1, rise);
        chk("wto1_delay", rise - kick_edge, 10);
        wr1(8'h13, BASE + 32'h1C, 32'd1);
        @(negedge ACLK);
        chk("wto1_cleared", WTO[1], 0);

        // INCR burst into channel 2: EN on beat 0, TOCNT=7 on beat 2; counting starts after
        // the TOCNT edge, so WTO[2] is due 6 edges after the final beat.
        bd[0] = 1; bd[1] = 0; bd[2] = 7; bd[3] = 0;
        for (int i = 0; i < 4; i++) bs[i] = 4'hF;
        burst(8'h21, BASE + 32'h20, 2'b01, 4, 0);
        wait_wto(2, rise);
        chk("wto2_delay", rise - beat_edge, 6);
        // FIXED burst hits CTRL2 four times; the final 0 leaves the channel disabled.
        burst(8'h22, BASE + 32'h20, 2'b00, 4, 0);
        wr1(8'h23, BASE + 32'h2C, 32'd1);
        repeat (20) @(negedge ACLK);
        chk("wto2_disabled", WTO[2], 0);

        // Unmapped and misaligned writes with a stalled response.
        bd[0] = 32'd3; bs[0] = 4'hF;
        burst(8'h31, BASE + 32'(16 * NUM_CH) + 32'h4, 2'b01, 1, 4);
        bd[0] = 32'd0;
        burst(8'h32, BASE + 32'h2, 2'b01, 1, 4);
        for (int i = 0; i < 4; i++) begin bd[i] = 0; bs[i] = 4'hF; end
        burst(8'h33, BASE + 32'h38, 2'b01, 4, 0);

        // Randomized bursts checked by the scoreboard and the watchdog model.
        repeat (40) begin
            n = $urandom_range(1, 4);
            hold = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0)
                a = BASE + 32'(16 * NUM_CH) + 32'($urandom_range(0, 3) * 4);
            else if ($urandom_range(0, 7) == 0)
                a = BASE + 32'($urandom_range(0, 63));
            else
                a = BASE + 32'($urandom_range(0, 15) * 4);
            for (int i = 0; i < n; i++) begin
                bd[i] = 32'($urandom_range(0, 20));
                bs[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            end
            burst(8'($urandom), a, 2'($urandom_range(0, 3)), n, hold);
            repeat ($urandom_range(0, 4)) @(posedge ACLK);
        end

        // Make sure WTO has a set bit, then reset in the middle of a DATA phase.
        wr1(8'h41, BASE + 32'h38, 32'd1);
        wr1(8'h41, BASE + 32'h30, 32'd1);
        repeat (5) @(negedge ACLK);
        chk("wto3_set", WTO[3], 1);
        @(posedge ACLK); #1;
        AWVALID_S = 1; AWID_S = 8'h77; AWADDR_S = BASE + 32'h8; AWLEN_S = 4'd3; AWBURST_S = 2'b01;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        AWVALID_S = 0; WVALID_S = 1; WDATA_S = 32'd9; WSTRB_S = 4'hF; WLAST_S = 0;
        @(negedge ACLK);
        chk("mid_burst_wready", WREADY_S, 1);
        @(posedge ACLK); #1;
        ARESETn = 0;
        #1;
        chk("arst_awready", AWREADY_S, 1);
        chk("arst_wready", WREADY_S, 0);
        chk("arst_bvalid", BVALID_S, 0);
        chk("arst_bid", BID_S, 0);
        chk("arst_bresp", BRESP_S, 0);
        chk("arst_wto", WTO, 0);
        WVALID_S = 0;
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1;
        wr1(8'h5A, BASE + 32'h30, 32'd1);
        repeat (5) @(posedge ACLK);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
